// File: rtl/posit_div_sequencer.sv
// posit_div_sequencer
//   Shares one restoring, one-bit-per-cycle mantissa divider between two
//   requesters using round-robin arbitration. Each result carries
//   q = floor((mant1 << N) / mant2), a sticky (non-zero remainder) bit, and
//   the sign/inf/zero flags of its request.
//
//   Optional feature macro: POSIT_DIV_FASTPATH_EN
//     defined   : special-value and zero-divisor requests skip CALC (DONE in 1 cycle)
//     undefined : every request iterates 2N cycles; special results are masked to 0
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[1:0]             per-requester operand valid
//   req_ready[1:0]             per-requester accept (combinational, one-hot or zero)
//   mant1_x, mant2_x           dividend / divisor mantissas of requester x
//   sign1/2, zero1/2, inf1/2   per-requester operand flags (bit x = requester x)
//   out_valid, out_ready       result handshake
//   out_id                     requester that owns the result
//   q, sticky                  quotient and non-zero-remainder flag
//   sign, inf, zero            result flags
module posit_div_sequencer #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(2*N)+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [N-1:0]     mant1_0,
    input  logic [N-1:0]     mant2_0,
    input  logic [N-1:0]     mant1_1,
    input  logic [N-1:0]     mant2_1,
    input  logic [1:0]       sign1,
    input  logic [1:0]       sign2,
    input  logic [1:0]       zero1,
    input  logic [1:0]       zero2,
    input  logic [1:0]       inf1,
    input  logic [1:0]       inf2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_id,
    output logic [2*N-1:0]   q,
    output logic             sticky,
    output logic             sign,
    output logic             inf,
    output logic             zero
);

    localparam int unsigned QW = 2*N;
    localparam int unsigned RW = N+1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           last_id;
    logic [1:0]     grant;
    logic           accept;
    logic           sel;
    logic [N-1:0]   sel_m1;
    logic [N-1:0]   sel_m2;
    logic           sel_sign;
    logic           sel_inf;
    logic           sel_zero;
    logic           sel_special;
    logic           take_fast;

    logic [RW-1:0]  rem;
    logic [QW-1:0]  dsr;
    logic [N-1:0]   dvs;
    logic [CW-1:0]  cnt;
    logic           special_q;

    logic [RW:0]    rem_sh;
    logic           ge;
    logic [RW-1:0]  rem_nxt;
    logic           last_step;

    // Round-robin grant: a tie goes to the requester that was not served last
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_id ? 2'b01 : 2'b10;
        end
    end

    assign accept = |(req_valid & req_ready);
    assign sel    = grant[1];

    // Operand and flag selection for the granted requester
    assign sel_m1      = sel ? mant1_1 : mant1_0;
    assign sel_m2      = sel ? mant2_1 : mant2_0;
    assign sel_sign    = sign1[sel] ^ sign2[sel];
    assign sel_inf     = inf1[sel] | inf2[sel] | (sel_m2 == '0);
    assign sel_zero    = zero1[sel] | zero2[sel];
    assign sel_special = sel_inf | sel_zero;

`ifdef POSIT_DIV_FASTPATH_EN
    assign take_fast = sel_special;
`else
    assign take_fast = 1'b0;
`endif

    // One restoring step; R' is one bit wider than R so the compare never wraps
    assign rem_sh    = {rem, dsr[QW-1]};
    assign ge        = rem_sh >= (RW+1)'(dvs);
    assign rem_nxt   = ge ? RW'(rem_sh - (RW+1)'(dvs)) : RW'(rem_sh);
    assign last_step = (cnt == CW'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = take_fast ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        req_ready = 2'b00;
        out_valid = 1'b0;
        if (state == IDLE) req_ready = grant;
        if (state == DONE) out_valid = 1'b1;
    end

    // Operand capture and divider datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id   <= 1'b1;
            out_id    <= 1'b0;
            sign      <= 1'b0;
            inf       <= 1'b0;
            zero      <= 1'b0;
            special_q <= 1'b0;
            rem       <= '0;
            dsr       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            q         <= '0;
            sticky    <= 1'b0;
        end else if (accept) begin
            last_id   <= sel;
            out_id    <= sel;
            sign      <= sel_sign;
            inf       <= sel_inf;
            zero      <= sel_zero;
            special_q <= sel_special;
            rem       <= '0;
            dsr       <= {sel_m1, {N{1'b0}}};
            dvs       <= sel_m2;
            cnt       <= CW'(QW);
            q         <= '0;
            sticky    <= 1'b0;
        end else if (state == CALC) begin
            rem <= rem_nxt;
            dsr <= {dsr[QW-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            // Special-value results are forced to zero on the final step
            if (last_step && special_q) begin
                q      <= '0;
                sticky <= 1'b0;
            end else begin
                q <= {q[QW-2:0], ge};
                if (last_step) sticky <= (rem_nxt != '0);
            end
        end
    end

endmodule
